// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM port among NUM_REQ masters.
// A tag FIFO records {owner, burstcount} per accepted read so return beats are steered back.
module sdram_port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int BURST_W   = 8,
  parameter int TAG_DEPTH = 8
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_address,
  input  logic [NUM_REQ*BURST_W-1:0]    req_burstcount,
  input  logic [NUM_REQ-1:0]            req_read,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*DATA_W-1:0]     req_writedata,
  input  logic [NUM_REQ*DATA_W/8-1:0]   req_byteenable,
  output logic [NUM_REQ-1:0]            req_waitrequest,
  output logic [DATA_W-1:0]             req_readdata,
  output logic [NUM_REQ-1:0]            req_readdatavalid,
  output logic [ADDR_W-1:0]             avm_address,
  output logic [BURST_W-1:0]            avm_burstcount,
  output logic                          avm_read,
  output logic                          avm_write,
  output logic [DATA_W-1:0]             avm_writedata,
  output logic [DATA_W/8-1:0]           avm_byteenable,
  input  logic                          avm_waitrequest,
  input  logic [DATA_W-1:0]             avm_readdata,
  input  logic                          avm_readdatavalid
);
  localparam int GW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW   = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {ARB = 2'd0, CMD = 2'd1, WBURST = 2'd2} state_t;

  state_t              state_r, state_s;
  logic [GW-1:0]       ptr_r, ptr_s, grant_r, grant_s, pick_s, grant_inc_s;
  logic [BURST_W-1:0]  beats_left_r, beats_left_s, ret_cnt_r, head_len_s;
  logic [GW-1:0]       tag_owner_r [TAG_DEPTH];
  logic [BURST_W-1:0]  tag_len_r [TAG_DEPTH];
  logic [TW-1:0]       wr_idx_r, rd_idx_r;
  logic [TW:0]         count_r;
  logic [NUM_REQ-1:0]  active_s;
  logic                g_read_s, g_write_s, rd_acc_s, wr_acc_s;
  logic                push_s, pop_s, beat_s, empty_s, full_s, block_s;

  assign active_s       = req_read | req_write;
  assign g_read_s       = req_read[grant_r];
  assign g_write_s      = req_write[grant_r];
  assign avm_address    = req_address[int'(grant_r)*ADDR_W +: ADDR_W];
  assign avm_burstcount = req_burstcount[int'(grant_r)*BURST_W +: BURST_W];
  assign avm_writedata  = req_writedata[int'(grant_r)*DATA_W +: DATA_W];
  assign avm_byteenable = req_byteenable[int'(grant_r)*BE_W +: BE_W];
  assign grant_inc_s    = (grant_r == GW'(NUM_REQ-1)) ? '0 : grant_r + 1'b1;

  assign head_len_s = tag_len_r[rd_idx_r];
  assign empty_s    = (count_r == '0);
  assign full_s     = (count_r == (TW+1)'(TAG_DEPTH));
  assign beat_s     = avm_readdatavalid & ~empty_s;
  assign pop_s      = beat_s & (ret_cnt_r == head_len_s - BURST_W'(1));
  // A final return beat frees its slot in the same cycle, so a full FIFO can still accept then.
  assign block_s    = full_s & ~pop_s;
  assign push_s     = rd_acc_s;
  assign req_readdata = avm_readdata;

  // Round-robin pick: scanning downward lets the nearest requester after ptr win.
  always_comb begin
    pick_s = ptr_r;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      pick_s = active_s[(int'(ptr_r) + k) % NUM_REQ] ? GW'((int'(ptr_r) + k) % NUM_REQ) : pick_s;
    end
  end

  // Next-state, grant/pointer update and command-side strobes.
  always_comb begin
    state_s         = state_r;
    grant_s         = grant_r;
    ptr_s           = ptr_r;
    beats_left_s    = beats_left_r;
    avm_read        = 1'b0;
    avm_write       = 1'b0;
    req_waitrequest = '1;
    rd_acc_s        = 1'b0;
    wr_acc_s        = 1'b0;
    case (state_r)
      ARB: begin
        if (|active_s) begin
          grant_s = pick_s;
          state_s = CMD;
        end else begin
          state_s = ARB;
        end
      end
      CMD: begin
        avm_read  = g_read_s & ~block_s;
        avm_write = g_write_s & ~g_read_s;
        req_waitrequest[grant_r] = avm_waitrequest | (g_read_s & block_s);
        rd_acc_s = avm_read & ~avm_waitrequest;
        wr_acc_s = avm_write & ~avm_waitrequest;
        if (rd_acc_s) begin
          ptr_s   = grant_inc_s;
          state_s = ARB;
        end else if (wr_acc_s) begin
          ptr_s = grant_inc_s;
          if (avm_burstcount > BURST_W'(1)) begin
            beats_left_s = avm_burstcount - BURST_W'(1);
            state_s      = WBURST;
          end else begin
            state_s = ARB;
          end
        end else if (!g_read_s && !g_write_s) begin
          state_s = ARB;
        end else begin
          state_s = CMD;
        end
      end
      WBURST: begin
        avm_write = g_write_s;
        req_waitrequest[grant_r] = avm_waitrequest;
        wr_acc_s = avm_write & ~avm_waitrequest;
        if (wr_acc_s) begin
          beats_left_s = beats_left_r - BURST_W'(1);
          state_s      = (beats_left_r == BURST_W'(1)) ? ARB : WBURST;
        end else begin
          state_s = WBURST;
        end
      end
      default: begin
        state_s = ARB;
      end
    endcase
  end

  // Return-beat steering to the owner recorded at the FIFO head.
  always_comb begin
    req_readdatavalid = '0;
    if (beat_s) begin
      req_readdatavalid[tag_owner_r[rd_idx_r]] = 1'b1;
    end else begin
      req_readdatavalid = '0;
    end
  end

  // Arbiter state, write-burst counter and tag FIFO storage.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r      <= ARB;
      ptr_r        <= '0;
      grant_r      <= '0;
      beats_left_r <= '0;
      wr_idx_r     <= '0;
      rd_idx_r     <= '0;
      count_r      <= '0;
      ret_cnt_r    <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_owner_r[i] <= '0;
        tag_len_r[i]   <= '0;
      end
    end else begin
      state_r      <= state_s;
      ptr_r        <= ptr_s;
      grant_r      <= grant_s;
      beats_left_r <= beats_left_s;
      count_r      <= count_r + (TW+1)'(push_s) - (TW+1)'(pop_s);
      if (push_s) begin
        tag_owner_r[wr_idx_r] <= grant_r;
        tag_len_r[wr_idx_r]   <= avm_burstcount;
        wr_idx_r              <= wr_idx_r + 1'b1;
      end
      if (pop_s) begin
        rd_idx_r <= rd_idx_r + 1'b1;
      end
      if (beat_s) begin
        ret_cnt_r <= pop_s ? '0 : ret_cnt_r + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a vector table for the basic read/write paths,
// then hand-written sequences for fairness, FIFO-full, interleaved returns and reset.
module tb_sdram_port_arbiter;
  localparam int N = 4, AW = 30, DW = 32, BW = 8;

  typedef struct {
    logic [3:0]  rd, wr;
    logic [7:0]  bc;
    logic        wt, rdv;
    logic [31:0] rdata;
    logic        e_rd, e_wr;
    logic [29:0] e_addr;
    logic [3:0]  e_wait, e_rdv;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [N-1:0] rd_v = '0, wr_v = '0;
  logic [BW-1:0] bc_v [N];
  logic wt = 1'b0, rdv = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [N*AW-1:0] req_address;
  logic [N*BW-1:0] req_burstcount;
  logic [N*DW-1:0] req_writedata;
  logic [N*DW/8-1:0] req_byteenable;
  logic [N-1:0] req_waitrequest, req_readdatavalid;
  logic [DW-1:0] req_readdata, avm_writedata;
  logic [AW-1:0] avm_address;
  logic [BW-1:0] avm_burstcount;
  logic avm_read, avm_write;
  logic [DW/8-1:0] avm_byteenable;
  int applied = 0, miscompares = 0;
  vec_t vecs [$];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_address[i*AW +: AW]     = AW'(32'h100 * (i + 1));
      req_burstcount[i*BW +: BW]  = bc_v[i];
      req_writedata[i*DW +: DW]   = 32'hA000_0000 | 32'(i);
      req_byteenable[i*4 +: 4]    = 4'hF;
    end
  end

  sdram_port_arbiter dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .req_address(req_address), .req_burstcount(req_burstcount),
    .req_read(rd_v), .req_write(wr_v),
    .req_writedata(req_writedata), .req_byteenable(req_byteenable),
    .req_waitrequest(req_waitrequest), .req_readdata(req_readdata),
    .req_readdatavalid(req_readdatavalid),
    .avm_address(avm_address), .avm_burstcount(avm_burstcount),
    .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(wt), .avm_readdata(rdata), .avm_readdatavalid(rdv)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample point mid-cycle; also flags illegal burstcount 0 from the stimulus.
  task automatic settle();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (rst_n && (rd_v[i] || wr_v[i]) && bc_v[i] == 8'd0) begin
        miscompares++;
        $display("FAIL bc0: requester %0d drives burstcount 0, expected >= 1", i);
      end
    end
  endtask

  task automatic do_reset();
    rd_v = '0; wr_v = '0; wt = 1'b0; rdv = 1'b0;
    for (int i = 0; i < N; i++) bc_v[i] = 8'd1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic [3:0] rd, input logic [3:0] wr, input logic [7:0] bc,
                              input logic w, input logic r, input logic [31:0] d,
                              input logic er, input logic ew, input logic [29:0] ea,
                              input logic [3:0] ewt, input logic [3:0] erv);
    vec_t v;
    v.rd = rd; v.wr = wr; v.bc = bc; v.wt = w; v.rdv = r; v.rdata = d;
    v.e_rd = er; v.e_wr = ew; v.e_addr = ea; v.e_wait = ewt; v.e_rdv = erv;
    return v;
  endfunction

  initial begin
    int gcount [N];
    int acc_n;
    int beat;
    logic [6:0] pat;

    for (int i = 0; i < N; i++) bc_v[i] = 8'd1;

    // Reset values, with requests and a stale return beat already present.
    #1 rst_n = 1'b0;
    rd_v = 4'hF; rdv = 1'b1;
    #2;
    chk("rst.read", 32'(avm_read), 32'd0);
    chk("rst.write", 32'(avm_write), 32'd0);
    chk("rst.wait", 32'(req_waitrequest), 32'hF);
    chk("rst.rdv", 32'(req_readdatavalid), 32'h0);
    do_reset();

    // Single read burst from req 0, then write burst hold by req 1 against req 2.
    vecs.push_back(mk(4'b0001, 4'b0000, 8'd4, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 30'h0, 4'b1111, 4'b0000));
    vecs.push_back(mk(4'b0001, 4'b0000, 8'd4, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 30'h100, 4'b1110, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0000, 8'd4, 1'b0, 1'b1, 32'hD0D0_0000, 1'b0, 1'b0, 30'h0, 4'b1111, 4'b0001));
    vecs.push_back(mk(4'b0000, 4'b0000, 8'd4, 1'b0, 1'b1, 32'hD0D0_0001, 1'b0, 1'b0, 30'h0, 4'b1111, 4'b0001));
    vecs.push_back(mk(4'b0000, 4'b0000, 8'd4, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 30'h0, 4'b1111, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0000, 8'd4, 1'b0, 1'b1, 32'hD0D0_0002, 1'b0, 1'b0, 30'h0, 4'b1111, 4'b0001));
    vecs.push_back(mk(4'b0000, 4'b0000, 8'd4, 1'b0, 1'b1, 32'hD0D0_0003, 1'b0, 1'b0, 30'h0, 4'b1111, 4'b0001));
    vecs.push_back(mk(4'b0000, 4'b0000, 8'd4, 1'b0, 1'b1, 32'hDEAD_0000, 1'b0, 1'b0, 30'h0, 4'b1111, 4'b0000));
    vecs.push_back(mk(4'b0100, 4'b0010, 8'd8, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 30'h0, 4'b1111, 4'b0000));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(4'b0100, 4'b0010, 8'd8, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 30'h200, 4'b1101, 4'b0000));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(4'b0100, 4'b0000, 8'd8, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 30'h0, 4'b1101, 4'b0000));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(4'b0100, 4'b0010, 8'd8, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 30'h200, 4'b1101, 4'b0000));
    vecs.push_back(mk(4'b0100, 4'b0000, 8'd1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 30'h0, 4'b1111, 4'b0000));
    vecs.push_back(mk(4'b0100, 4'b0000, 8'd1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 30'h300, 4'b1111, 4'b0000));
    vecs.push_back(mk(4'b0100, 4'b0000, 8'd1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 30'h300, 4'b1011, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0000, 8'd1, 1'b0, 1'b1, 32'hE0E0_0000, 1'b0, 1'b0, 30'h0, 4'b1111, 4'b0100));
    vecs.push_back(mk(4'b0000, 4'b0000, 8'd1, 1'b0, 1'b1, 32'hDEAD_0001, 1'b0, 1'b0, 30'h0, 4'b1111, 4'b0000));

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      rd_v = v.rd; wr_v = v.wr; wt = v.wt; rdv = v.rdv; rdata = v.rdata;
      for (int j = 0; j < N; j++) bc_v[j] = v.bc;
      settle();
      chk($sformatf("v%0d.read", i), 32'(avm_read), 32'(v.e_rd));
      chk($sformatf("v%0d.write", i), 32'(avm_write), 32'(v.e_wr));
      chk($sformatf("v%0d.wait", i), 32'(req_waitrequest), 32'(v.e_wait));
      chk($sformatf("v%0d.rdv", i), 32'(req_readdatavalid), 32'(v.e_rdv));
      if (v.e_addr != 30'h0) chk($sformatf("v%0d.addr", i), 32'(avm_address), 32'(v.e_addr));
      if (v.e_rdv != 4'b0000) chk($sformatf("v%0d.rdata", i), req_readdata, v.rdata);
      tick();
    end
    rd_v = '0; wr_v = '0; rdv = 1'b0;

    // Fairness: 64 single-beat reads from all four, each beat returned right after accept.
    do_reset();
    for (int i = 0; i < N; i++) gcount[i] = 0;
    rd_v = 4'hF;
    for (int c = 0; c < 129; c++) begin
      if (c == 128) rd_v = '0;
      rdv = (c >= 2 && c % 2 == 0);
      rdata = 32'hF000_0000 | 32'(c);
      settle();
      if (c % 2 == 1) begin
        chk("fair.read", 32'(avm_read), 32'd1);
        chk("fair.grant", 32'(req_waitrequest), 32'(4'(~(4'b0001 << ((c / 2) % 4)))));
        for (int i = 0; i < N; i++) if (avm_read && !req_waitrequest[i]) gcount[i]++;
      end else if (c >= 2) begin
        chk("fair.rdv", 32'(req_readdatavalid), 32'(4'b0001 << ((c / 2 - 1) % 4)));
      end
      tick();
    end
    rdv = 1'b0;
    for (int i = 0; i < N; i++) chk($sformatf("fair.count%0d", i), 32'(gcount[i]), 32'd16);

    // Tag FIFO full: eight reads outstanding, ninth held until a final beat frees a slot.
    do_reset();
    rd_v = 4'hF;
    for (int k = 0; k < 8; k++) begin
      tick();
      settle();
      chk("full.fill", 32'(req_waitrequest), 32'(4'(~(4'b0001 << (k % 4)))));
      tick();
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("full.hold_read", 32'(avm_read), 32'd0);
      chk("full.hold_wait", 32'(req_waitrequest), 32'hF);
      tick();
    end
    rdv = 1'b1; rdata = 32'hBEEF_0000;
    settle();
    chk("full.pop_read", 32'(avm_read), 32'd1);
    chk("full.pop_wait", 32'(req_waitrequest), 32'hE);
    chk("full.pop_rdv", 32'(req_readdatavalid), 32'h1);
    tick();
    rdv = 1'b0;
    tick();
    settle();
    chk("full.still8_read", 32'(avm_read), 32'd0);
    tick();
    rdv = 1'b1;
    settle();
    chk("full.pop2_read", 32'(avm_read), 32'd1);
    chk("full.pop2_rdv", 32'(req_readdatavalid), 32'h2);
    tick();
    rd_v = '0;
    for (int j = 0; j < 8; j++) begin
      settle();
      chk("full.drain", 32'(req_readdatavalid), 32'(4'b0001 << ((j + 2) % 4)));
      tick();
    end
    settle();
    chk("full.empty", 32'(req_readdatavalid), 32'h0);
    tick();
    rdv = 1'b0;

    // Interleaved returns: req 0 burst 2 then req 3 burst 3 under random waitrequest.
    do_reset();
    bc_v[0] = 8'd2; bc_v[3] = 8'd3;
    rd_v = 4'b1001;
    acc_n = 0;
    for (int b = 0; b < 40 && acc_n < 2; b++) begin
      wt = 1'($urandom_range(0, 1));
      settle();
      if (avm_read) begin
        chk("il.wait", 32'(req_waitrequest),
            wt ? 32'hF : 32'(4'(~(4'b0001 << ((acc_n == 0) ? 0 : 3)))));
      end
      if (avm_read && !wt) begin
        chk("il.addr", 32'(avm_address), (acc_n == 0) ? 32'h100 : 32'h400);
        chk("il.bc", 32'(avm_burstcount), (acc_n == 0) ? 32'd2 : 32'd3);
        acc_n++;
        tick();
        if (acc_n == 1) rd_v[0] = 1'b0; else rd_v[3] = 1'b0;
      end else begin
        tick();
      end
    end
    chk("il.accepts", 32'(acc_n), 32'd2);
    rd_v = '0; wt = 1'b0;
    pat = 7'b1101011;
    beat = 0;
    for (int j = 0; j < 7; j++) begin
      rdv = pat[j];
      rdata = 32'hC0DE_0000 | 32'(j);
      settle();
      if (pat[j]) begin
        chk("il.rdv", 32'(req_readdatavalid), (beat < 2) ? 32'h1 : 32'h8);
        chk("il.rdata", req_readdata, 32'hC0DE_0000 | 32'(j));
        beat++;
      end else begin
        chk("il.gap", 32'(req_readdatavalid), 32'h0);
      end
      tick();
    end
    rdv = 1'b1;
    settle();
    chk("il.empty", 32'(req_readdatavalid), 32'h0);
    tick();
    rdv = 1'b0;

    // Reset with two bursts outstanding, stale data afterwards, then a clean read.
    do_reset();
    bc_v[0] = 8'd4; bc_v[1] = 8'd2;
    rd_v = 4'b0011;
    settle(); chk("mr.arb", 32'(avm_read), 32'd0); tick();
    settle(); chk("mr.addr0", 32'(avm_address), 32'h100); chk("mr.read0", 32'(avm_read), 32'd1); tick();
    rd_v = 4'b0010;
    settle(); tick();
    settle(); chk("mr.addr1", 32'(avm_address), 32'h200); chk("mr.read1", 32'(avm_read), 32'd1); tick();
    rd_v = '0; rdv = 1'b1; rdata = 32'h1111_0000;
    settle(); chk("mr.beat", 32'(req_readdatavalid), 32'h1); tick();
    rd_v = 4'b0011;
    #2 rst_n = 1'b0;
    #1;
    chk("mr.rst_read", 32'(avm_read), 32'd0);
    chk("mr.rst_write", 32'(avm_write), 32'd0);
    chk("mr.rst_wait", 32'(req_waitrequest), 32'hF);
    chk("mr.rst_rdv", 32'(req_readdatavalid), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rd_v = '0;
    for (int i = 0; i < N; i++) bc_v[i] = 8'd1;
    for (int k = 0; k < 2; k++) begin
      settle(); chk("mr.stale", 32'(req_readdatavalid), 32'h0); tick();
    end
    rdv = 1'b0;
    rd_v = 4'b0100;
    settle(); chk("mr.new_arb", 32'(avm_read), 32'd0); tick();
    settle();
    chk("mr.new_read", 32'(avm_read), 32'd1);
    chk("mr.new_addr", 32'(avm_address), 32'h300);
    chk("mr.new_wait", 32'(req_waitrequest), 32'hB);
    tick();
    rd_v = '0; rdv = 1'b1; rdata = 32'h2222_0000;
    settle(); chk("mr.new_rdv", 32'(req_readdatavalid), 32'h4); chk("mr.new_rdata", req_readdata, 32'h2222_0000); tick();
    settle(); chk("mr.new_empty", 32'(req_readdatavalid), 32'h0); tick();
    rdv = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Round-robin arbiter that shares the HPS FPGA-to-SDRAM Avalon-MM port (`hps_0_f2h_sdram0_data_*`) between `NUM_REQ` GPU-side Avalon-MM masters, such as shader-core fetch units and the video scanout reader. It grants one requester at a time, holds the grant for a full write burst, and tracks outstanding read bursts in a tag FIFO. Read data returning from SDRAM is steered back to the requester that issued the read. It sits between the GPU memory clients and the `soc_system` f2h_sdram0 slave.

## Interface
- `NUM_REQ`, 4: number of requesters.
- `ADDR_W`, 30: word address width.
- `DATA_W`, 32: data width.
- `BURST_W`, 8: burstcount width.
- `TAG_DEPTH`, 8: maximum outstanding read bursts (power of 2).
- `clk_clk` in 1: single clock for the whole block.
- `reset_reset_n` in 1: reset, asynchronous assert, active-low.
- `req_address` in NUM_REQ*ADDR_W: per-requester address; requester i occupies slice i.
- `req_burstcount` in NUM_REQ*BURST_W: per-requester burst length.
- `req_read` in NUM_REQ: per-requester read strobe.
- `req_write` in NUM_REQ: per-requester write strobe.
- `req_writedata` in NUM_REQ*DATA_W: per-requester write data.
- `req_byteenable` in NUM_REQ*DATA_W/8: per-requester byte enables.
- `req_waitrequest` out NUM_REQ: per-requester waitrequest.
- `req_readdata` out DATA_W: shared read data, valid only where `req_readdatavalid` is set.
- `req_readdatavalid` out NUM_REQ: one-hot read-data qualifier.
- `avm_address`, `avm_burstcount`, `avm_read`, `avm_write`, `avm_writedata`, `avm_byteenable` out: master side; connect to `hps_0_f2h_sdram0_data_*`.
- `avm_waitrequest`, `avm_readdata`, `avm_readdatavalid` in: master-side responses.

## Operation
- FSM states: ARB, CMD, WBURST.
- ARB
  - If no requester asserts read|write, stay in ARB.
  - Otherwise pick the first requester with read|write asserted, searching from `ptr` (round-robin, wrapping at NUM_REQ-1 to 0).
  - Register `grant` and go to CMD.
  - `ptr` is set to grant+1 (mod NUM_REQ) when the granted command is accepted.
- CMD
  - All `avm_*` command outputs are a combinational mux of the granted requester's signals.
  - `req_waitrequest[grant]` = `avm_waitrequest`; all other requesters see waitrequest=1.
  - Read accepted (`avm_read` & !`avm_waitrequest`): push {grant, burstcount} into the tag FIFO, then go to ARB.
  - If the tag FIFO is full: `avm_read` is forced 0 and `req_waitrequest[grant]`=1 until a pop frees a slot.
  - Write first beat accepted, burstcount==1: go to ARB.
  - Write first beat accepted, burstcount>1: load beats_left = burstcount-1 and go to WBURST.
- WBURST
  - Grant is held; the mux still passes write/writedata/byteenable through.
  - beats_left decrements on each accepted beat.
  - Go to ARB on the beat that brings beats_left to 0.
  - The requester may stall (deassert write) mid-burst; the arbiter keeps the grant.
- Read return
  - The head tag gives the owner and the beat count.
  - On each `avm_readdatavalid`: pass `avm_readdata` to `req_readdata` and set `req_readdatavalid[owner]`, combinationally, same cycle.
  - Decrement the return-beat counter; pop the tag on the final beat.
  - Push and pop in the same cycle are legal; occupancy is unchanged.
- `avm_readdatavalid` with an empty tag FIFO (e.g. data from before a reset) is dropped; no requester valid is asserted.
- Writes may be issued while reads are outstanding; ordering is the slave's responsibility.
- Burstcount 0 is illegal from requesters; the bench flags it as an error.

## Timing
- Reset values:
  - state=ARB, ptr=0, grant=0.
  - Tag FIFO empty, beats_left=0.
  - `avm_read`=`avm_write`=0.
  - `req_waitrequest`=all 1s, `req_readdatavalid`=0.
- Arbitration latency: a request at cycle 0 in ARB is presented on `avm_*` in cycle 1, and accepted at the cycle 1 edge if `avm_waitrequest`=0.
- Minimum 2 cycles per granted command (one ARB bubble).
- Read-data path: 0 cycles from `avm_readdatavalid` to `req_readdatavalid`.
- Reset mid-operation:
  - Asynchronous clear of all state.
  - In-flight bursts are abandoned.
  - Returning data is discarded as described above.

## Test plan
- Single requester, read burst: req 0 reads addr 0x100, burstcount 4 → avm_address=0x100 in cycle 1; 4 returned beats appear only on `req_readdatavalid[0]`; tag FIFO is empty afterwards.
- Fairness: all 4 requesters issue single-beat reads continuously with `avm_waitrequest`=0 → grant order is 0,1,2,3,0,…; each requester gets exactly 25% of accepts over 64 commands.
- Write burst hold: req 1 writes burstcount 8 while req 2 requests → req 2 sees waitrequest=1 until req 1's 8th beat is accepted. Inject a 3-cycle stall by req 1 at beat 4; the grant is still held.
- Tag FIFO full: 8 outstanding reads with no returns → the 9th read is held with `avm_read`=0. A final return beat frees a slot, and a push in the same cycle as the pop leaves occupancy at 8.
- Interleaved returns: req 0 burst 2, then req 3 burst 3, with `avm_waitrequest` toggling randomly → valids go to req 0 ×2, then req 3 ×3, with data matching in order.
- Reset mid-read: assert reset with 2 bursts outstanding → all outputs are at reset values immediately. Stale `avm_readdatavalid` after release produces no `req_readdatavalid`, and a new read completes normally.
